// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a runtime-selectable frame format.
// Ports:
//   i_clkx16           sampling clock, OVS x baud rate
//   i_rst_n            asynchronous active-low reset
//   i_rx               serial line, idle high, asynchronous to i_clkx16
//   i_bitnum           data bits per frame (clamped to 5..MAX_BITS when latched)
//   i_exist_oddcheck   odd parity bit present (wins when both parity inputs are set)
//   i_exist_evencheck  even parity bit present
//   i_exist_stop       stop bit(s) present
//   i_stop2            two stop bits when i_exist_stop=1
//   o_data             received word, LSB-aligned, unused MSBs zero
//   o_data_valid       one-cycle pulse when a frame completes
//   o_parity_err       parity mismatch, qualified by o_data_valid
//   o_frame_err        a stop bit was sampled low, qualified by o_data_valid
//   o_busy             high whenever a frame is in progress
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority of
// three consecutive mid-bit samples; the decision then lands one tick later.
module uart_rx_param #(
    parameter int unsigned OVS      = 16,
    parameter int unsigned MAX_BITS = 8
) (
    input  logic                i_clkx16,
    input  logic                i_rst_n,
    input  logic                i_rx,
    input  logic [3:0]          i_bitnum,
    input  logic                i_exist_oddcheck,
    input  logic                i_exist_evencheck,
    input  logic                i_exist_stop,
    input  logic                i_stop2,
    output logic [MAX_BITS-1:0] o_data,
    output logic                o_data_valid,
    output logic                o_parity_err,
    output logic                o_frame_err,
    output logic                o_busy
);

    localparam int unsigned TW = $clog2(OVS);
    localparam int unsigned IW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned SAMPLE_TICK = OVS / 2;
`else
    localparam int unsigned SAMPLE_TICK = OVS / 2 - 1;
`endif

    typedef enum logic [2:0] {IDLE, START, RDATA, CHECK, STOP} state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         last_q, last_d;
    logic                  odd_q, odd_d;
    logic                  par_en_q, par_en_d;
    logic                  stop_en_q, stop_en_d;
    logic                  stop2_q, stop2_d;
    logic [MAX_BITS-1:0]   shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  facc_q, facc_d;
    logic [MAX_BITS-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  busy_q, busy_d;
    logic                  sync1_q, rxs_q, rxp_q;
    logic                  rx_bit_c, sample_c, bit_end_c, last_bit_c, finish_c;
    logic [3:0]            bitnum_clamp_c;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge i_clkx16 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            rxp_q   <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            rxs_q   <= sync1_q;
            rxp_q   <= rxs_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic maj_a_q, maj_b_q;

    // Capture the two samples preceding the decision tick
    always_ff @(posedge i_clkx16 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else begin
            if (tick_q == TW'(OVS / 2 - 2)) maj_a_q <= rxs_q;
            if (tick_q == TW'(OVS / 2 - 1)) maj_b_q <= rxs_q;
        end
    end

    assign rx_bit_c = (maj_a_q & maj_b_q) | (maj_a_q & rxs_q) | (maj_b_q & rxs_q);
`else
    assign rx_bit_c = rxs_q;
`endif

    // Out-of-range bit counts snap to the nearest legal value
    always_comb begin
        bitnum_clamp_c = i_bitnum;
        if (i_bitnum < 4'd5)                 bitnum_clamp_c = 4'd5;
        else if (i_bitnum > 4'(MAX_BITS))    bitnum_clamp_c = 4'(MAX_BITS);
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + TW'(1);
        idx_d     = idx_q;
        last_d    = last_q;
        odd_d     = odd_q;
        par_en_d  = par_en_q;
        stop_en_d = stop_en_q;
        stop2_d   = stop2_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        facc_d    = facc_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;
        finish_c  = 1'b0;
        sample_c   = (tick_q == TW'(SAMPLE_TICK));
        bit_end_c  = (tick_q == TW'(OVS - 1));
        last_bit_c = (idx_q == last_q);

        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (rxp_q && !rxs_q) begin
                    state_d   = START;
                    idx_d     = '0;
                    last_d    = IW'(bitnum_clamp_c - 4'd1);
                    odd_d     = i_exist_oddcheck;
                    par_en_d  = i_exist_oddcheck | i_exist_evencheck;
                    stop_en_d = i_exist_stop;
                    stop2_d   = i_exist_stop & i_stop2;
                    shreg_d   = '0;
                    par_d     = 1'b0;
                    facc_d    = 1'b0;
                end
            end
            START: begin
                if (sample_c && rx_bit_c) state_d = IDLE;
                else if (bit_end_c)       state_d = RDATA;
            end
            RDATA: begin
                if (sample_c) begin
                    shreg_d[idx_q] = rx_bit_c;
                    par_d          = par_q ^ rx_bit_c;
                    if (last_bit_c && !par_en_q && !stop_en_q) finish_c = 1'b1;
                end
                if (bit_end_c) begin
                    if (last_bit_c) begin
                        idx_d   = '0;
                        state_d = par_en_q ? CHECK : STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            CHECK: begin
                if (sample_c) begin
                    par_d = par_q ^ rx_bit_c;
                    if (!stop_en_q) finish_c = 1'b1;
                end
                if (bit_end_c) begin
                    idx_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                // idx_q counts stop bits; finish right at the last stop sample
                if (sample_c) begin
                    facc_d = facc_q | ~rx_bit_c;
                    if (!stop2_q || idx_q == IW'(1)) finish_c = 1'b1;
                end
                if (bit_end_c) idx_d = IW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (finish_c) begin
            state_d = IDLE;
            valid_d = 1'b1;
            data_d  = shreg_d;
            perr_d  = par_en_q & (par_d != odd_q);
            ferr_d  = facc_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge i_clkx16 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            odd_q     <= 1'b0;
            par_en_q  <= 1'b0;
            stop_en_q <= 1'b0;
            stop2_q   <= 1'b0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            facc_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            odd_q     <= odd_d;
            par_en_q  <= par_en_d;
            stop_en_q <= stop_en_d;
            stop2_q   <= stop2_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            facc_q    <= facc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = busy_q;

endmodule
